// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared angle constants, default seed amplitude and sweep FSM states
// Angles use a 32-bit phase word where 2^32 represents one full turn.
package cordic_pkg;

  localparam logic [31:0] ANG_90      = 32'h4000_0000;
  localparam logic [31:0] ANG_180     = 32'h8000_0000;
  // 32000 / 1.647, pre-divided by the CORDIC gain
  localparam int          AMP_DEFAULT = 19429;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } sweep_state_e;

endpackage

// File: rtl/cordic_valid_dly.sv
// rtl/cordic_valid_dly.sv - DEPTH-deep shift register carrying {valid, index} tags
// Latency-matches the sample tag to the rotator pipeline; clearing empties every stage.
module cordic_valid_dly #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_index,
  output logic        out_valid,
  output logic [15:0] out_index
);

  logic [16:0] sr_q [DEPTH];
  logic [16:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = {in_valid, in_index};
    for (int i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '{default: '0};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign out_valid = sr_q[DEPTH-1][16];
  assign out_index = sr_q[DEPTH-1][15:0];

endmodule

// File: rtl/cordic_sweep_gen.sv
// rtl/cordic_sweep_gen.sv - phase sweep / seed generator feeding a pipelined CORDIC rotator
// Optional quadrant pre-rotation for full-circle coverage: CORDIC_SWEEP_QUAD_PREROT_EN.
module cordic_sweep_gen
  import cordic_pkg::*;
#(
  parameter int SZ       = 16,
  parameter int PIPE_LAT = 16,
  parameter int AMP      = AMP_DEFAULT
) (
  input  logic          CLK_100MHZ,
  input  logic          RST_N,
  input  logic          start,
  input  logic [31:0]   step,
  input  logic [15:0]   count,
  output logic [31:0]   angle,
  output logic [SZ-1:0] Xin,
  output logic [SZ-1:0] Yin,
  output logic          busy,
  output logic          out_valid,
  output logic [15:0]   out_index,
  output logic          done
);

  sweep_state_e  state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   step_q, step_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   idx_q, idx_d;
  logic [31:0]   angle_q, angle_d;
  logic [SZ-1:0] xin_q, xin_d;

  logic [31:0]   issue_angle;
  logic [SZ-1:0] issue_xin;
  logic [SZ-1:0] amp_pos;
  logic          last_issue;
  logic          last_out;
  logic          dly_valid;
  logic [15:0]   dly_index;

  assign amp_pos = SZ'(AMP);

  // acc_q always holds the phase of the sample after the one currently on angle_q
`ifdef CORDIC_SWEEP_QUAD_PREROT_EN
  logic [SZ-1:0] amp_neg;
  assign amp_neg = SZ'(-AMP);

  always_comb begin
    issue_angle = acc_q;
    issue_xin   = amp_pos;
    if (acc_q[31:30] == ANG_90[31:30] || acc_q[31:30] == ANG_180[31:30]) begin
      issue_angle = acc_q + ANG_180;
      issue_xin   = amp_neg;
    end
  end
`else
  always_comb begin
    issue_angle = acc_q;
    issue_xin   = amp_pos;
  end
`endif

  assign last_issue = (idx_q == count_q - 16'd1);
  assign last_out   = dly_valid && (dly_index == count_q - 16'd1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;
    count_d = count_q;
    idx_d   = idx_q;
    angle_d = '0;
    xin_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          step_d  = step;
          count_d = count;
          idx_d   = '0;
          acc_d   = step;
          if (count == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            xin_d   = amp_pos;
          end
        end
      end
      ST_RUN: begin
        if (last_issue) begin
          state_d = ST_DRAIN;
        end else begin
          angle_d = issue_angle;
          xin_d   = issue_xin;
          acc_d   = acc_q + step_q;
          idx_d   = idx_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        if (last_out) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_100MHZ) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      step_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      angle_q <= '0;
      xin_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      angle_q <= angle_d;
      xin_q   <= xin_d;
    end
  end

  // idx_q is pushed even with valid=0 so out_index holds its last value between sweeps
  cordic_valid_dly #(
    .DEPTH(PIPE_LAT)
  ) u_valid_dly (
    .clk      (CLK_100MHZ),
    .rst_n    (RST_N),
    .in_valid (state_q == ST_RUN),
    .in_index (idx_q),
    .out_valid(dly_valid),
    .out_index(dly_index)
  );

  assign angle     = angle_q;
  assign Xin       = xin_q;
  assign Yin       = '0;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign out_valid = dly_valid;
  assign out_index = dly_index;

endmodule

// File: tb/tb_cordic_sweep_gen.sv
// tb/tb_cordic_sweep_gen.sv - directed table-driven bench for cordic_sweep_gen
// Expected wrap values follow CORDIC_SWEEP_QUAD_PREROT_EN when it is defined.
module tb_cordic_sweep_gen;

  localparam int SZ       = 16;
  localparam int PIPE_LAT = 16;
  localparam logic [15:0] AMP_P = 16'h4BE5;
  localparam logic [15:0] AMP_N = 16'hB41B;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [31:0]   step;
  logic [15:0]   count;
  logic [31:0]   angle;
  logic [SZ-1:0] Xin;
  logic [SZ-1:0] Yin;
  logic          busy;
  logic          out_valid;
  logic [15:0]   out_index;
  logic          done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] step;
    logic [15:0] count;
    logic [31:0] exp_angle [5];
    logic [15:0] exp_xin   [5];
  } vec_t;

  vec_t vecs [5];

  cordic_sweep_gen #(
    .SZ      (SZ),
    .PIPE_LAT(PIPE_LAT)
  ) dut (
    .CLK_100MHZ(clk),
    .RST_N     (rst_n),
    .start     (start),
    .step      (step),
    .count     (count),
    .angle     (angle),
    .Xin       (Xin),
    .Yin       (Yin),
    .busy      (busy),
    .out_valid (out_valid),
    .out_index (out_index),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " angle"},     angle,           32'h0);
    chk({tag, " Xin"},       32'(Xin),        32'h0);
    chk({tag, " Yin"},       32'(Yin),        32'h0);
    chk({tag, " busy"},      32'(busy),       32'h0);
    chk({tag, " out_valid"}, 32'(out_valid),  32'h0);
    chk({tag, " out_index"}, 32'(out_index),  32'h0);
    chk({tag, " done"},      32'(done),       32'h0);
  endtask

  // called at a falling edge in cycle T; returns at the falling edge of cycle T+1
  task automatic do_start(input logic [31:0] s, input logic [15:0] c);
    start = 1'b1;
    step  = s;
    count = c;
    @(negedge clk);
    start = 1'b0;
    step  = 32'hDEAD_BEEF;
    count = 16'hFFFF;
  endtask

  task automatic run_sweep(input vec_t v, input int id);
    int  done_n;
    int  cnt;
    cnt    = int'(v.count);
    done_n = (cnt == 0) ? 1 : cnt + PIPE_LAT + 1;
    do_start(v.step, v.count);
    for (int n = 1; n <= done_n + 1; n++) begin
      chk($sformatf("v%0d busy n=%0d", id, n), 32'(busy), 32'(cnt != 0 && n < done_n));
      chk($sformatf("v%0d done n=%0d", id, n), 32'(done), 32'(n == done_n));
      chk($sformatf("v%0d out_valid n=%0d", id, n), 32'(out_valid),
          32'(cnt != 0 && n > PIPE_LAT && n < done_n));
      chk($sformatf("v%0d Yin n=%0d", id, n), 32'(Yin), 32'h0);
      if (cnt != 0 && n > PIPE_LAT && n < done_n)
        chk($sformatf("v%0d out_index n=%0d", id, n), 32'(out_index), 32'(n - 1 - PIPE_LAT));
      if (cnt != 0 && n >= done_n)
        chk($sformatf("v%0d out_index hold n=%0d", id, n), 32'(out_index), 32'(cnt - 1));
      if (n <= cnt && n <= 5) begin
        chk($sformatf("v%0d angle n=%0d", id, n), angle, v.exp_angle[n-1]);
        chk($sformatf("v%0d Xin n=%0d", id, n), 32'(Xin), 32'(v.exp_xin[n-1]));
      end else begin
        chk($sformatf("v%0d Xin idle n=%0d", id, n), 32'(Xin), 32'h0);
      end
      if (n == done_n + 1)
        chk($sformatf("v%0d angle idle n=%0d", id, n), angle, 32'h0);
      @(negedge clk);
    end
  endtask

  initial begin
    int dones;
    int ovs;
    int got_done;

    vecs[0].step = 32'h00B6_0B61; vecs[0].count = 16'd4;
    vecs[0].exp_angle = '{32'h0, 32'h00B6_0B61, 32'h016C_16C2, 32'h0222_2223, 32'h0};
    vecs[0].exp_xin   = '{AMP_P, AMP_P, AMP_P, AMP_P, 16'h0};

    vecs[1].step = 32'h4000_0000; vecs[1].count = 16'd5;
`ifdef CORDIC_SWEEP_QUAD_PREROT_EN
    vecs[1].exp_angle = '{32'h0, 32'hC000_0000, 32'h0, 32'hC000_0000, 32'h0};
    vecs[1].exp_xin   = '{AMP_P, AMP_N, AMP_N, AMP_P, AMP_P};
`else
    vecs[1].exp_angle = '{32'h0, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0};
    vecs[1].exp_xin   = '{AMP_P, AMP_P, AMP_P, AMP_P, AMP_P};
`endif

    vecs[2].step = 32'h1234_5678; vecs[2].count = 16'd0;
    vecs[2].exp_angle = '{default: 32'h0};
    vecs[2].exp_xin   = '{default: 16'h0};

    vecs[3].step = 32'hFFFF_FFFF; vecs[3].count = 16'd2;
    vecs[3].exp_angle = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};
    vecs[3].exp_xin   = '{AMP_P, AMP_P, 16'h0, 16'h0, 16'h0};

    vecs[4].step = 32'h3000_0000; vecs[4].count = 16'd3;
`ifdef CORDIC_SWEEP_QUAD_PREROT_EN
    vecs[4].exp_angle = '{32'h0, 32'h3000_0000, 32'hE000_0000, 32'h0, 32'h0};
    vecs[4].exp_xin   = '{AMP_P, AMP_P, AMP_N, 16'h0, 16'h0};
`else
    vecs[4].exp_angle = '{32'h0, 32'h3000_0000, 32'h6000_0000, 32'h0, 32'h0};
    vecs[4].exp_xin   = '{AMP_P, AMP_P, AMP_P, 16'h0, 16'h0};
`endif

    rst_n = 1'b0;
    start = 1'b0;
    step  = '0;
    count = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_sweep(vecs[i], i);
    end

    // start pulses in RUN and DRAIN are ignored; start right after done is taken
    dones = 0;
    ovs   = 0;
    do_start(32'h0100_0000, 16'd3);
    for (int n = 1; n <= 21; n++) begin
      if (done) begin
        dones++;
        chk("busy-seq done cycle", 32'(n), 32'd20);
      end
      if (out_valid) ovs++;
      if (n <= 3) chk($sformatf("busy-seq angle n=%0d", n), angle, 32'(32'h0100_0000 * (n - 1)));
      start = (n == 2 || n == 8 || n == 21);
      step  = (n == 21) ? 32'h1000_0000 : 32'h7000_0000;
      count = (n == 21) ? 16'd1 : 16'd9;
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy-seq done pulses", 32'(dones), 32'd1);
    chk("busy-seq out_valid cycles", 32'(ovs), 32'd3);
    chk("restart busy", 32'(busy), 32'd1);
    chk("restart angle", angle, 32'h0);
    chk("restart Xin", 32'(Xin), 32'(AMP_P));
    got_done = 0;
    for (int i = 0; i < 40 && got_done == 0; i++) begin
      if (out_valid) chk("restart out_index", 32'(out_index), 32'h0);
      if (done) got_done = 1;
      else @(negedge clk);
    end
    chk("restart done seen", 32'(got_done), 32'd1);
    @(negedge clk);

    // reset pulse while sample 2 of a 10-sample sweep is on the outputs
    do_start(32'h0100_0000, 16'd10);
    repeat (2) @(negedge clk);
    chk("midrst angle s2", angle, 32'h0200_0000);
    chk("midrst busy s2", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_vals("midrst");
    for (int i = 0; i < 2 * PIPE_LAT; i++) begin
      chk($sformatf("midrst out_valid i=%0d", i), 32'(out_valid), 32'h0);
      chk($sformatf("midrst busy i=%0d", i), 32'(busy), 32'h0);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
